// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the processor-memory arbiter: memory command encoding,
// address / block / tag widths, the owner enum and the owner-table entry.
// Defaults for the tag count and the starvation limit are supplied here
// when the surrounding build has not already defined them.

`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

`ifndef MEM_ARB_STARVE_LIMIT
`define MEM_ARB_STARVE_LIMIT 4
`endif

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    // Four bits covers tags 1..15; tag 0 always means "no tag".
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic {
        ARB_OWNER_I = 1'b0,
        ARB_OWNER_D = 1'b1
    } MEM_ARB_OWNER;

    typedef struct packed {
        logic         valid;
        MEM_ARB_OWNER owner;
    } MEM_ARB_ENTRY;

    localparam int MEM_ARB_NUM_TAGS     = `NUM_MEM_TAGS;
    localparam int MEM_ARB_STARVE_DEFLT = `MEM_ARB_STARVE_LIMIT;

endpackage

// File: rtl/mem_tag_owner_table.sv
// mem_tag_owner_table
// Register array of {valid, owner} entries indexed by memory tag.
// Ports:
//   clock, reset     clock and asynchronous active-low reset
//   i_setEn/i_setTag/i_setOwner   write port: mark a tag as owned
//   i_rdTag/o_rdEntry             combinational read of one entry
//   i_clrEn                       clear the entry addressed by i_rdTag
// A set and a clear of the same tag in one cycle leave the entry set with
// the new owner.

import mem_arbiter_pkg::*;

module mem_tag_owner_table #(
    parameter int NUM_TAGS = `NUM_MEM_TAGS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_setEn,
    input  MEM_TAG       i_setTag,
    input  MEM_ARB_OWNER i_setOwner,
    input  MEM_TAG       i_rdTag,
    input  logic         i_clrEn,
    output MEM_ARB_ENTRY o_rdEntry
);

    localparam MEM_TAG MAX_TAG = MEM_TAG'(NUM_TAGS);

    MEM_ARB_ENTRY r_table [0:NUM_TAGS];
    logic         w_setInRange;
    logic         w_rdInRange;

    assign w_setInRange = (i_setTag <= MAX_TAG);
    assign w_rdInRange  = (i_rdTag <= MAX_TAG);

    // Read port: tags beyond the table read back as an invalid entry.
    assign o_rdEntry = w_rdInRange ? r_table[i_rdTag] : '0;

    // Clear is written first so that a same-tag set later in the block
    // overrides it and the newly issued load keeps its owner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NUM_TAGS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (i_clrEn && w_rdInRange) begin
                r_table[i_rdTag] <= '0;
            end
            if (i_setEn && w_setInRange) begin
                r_table[i_setTag] <= '{valid: 1'b1, owner: i_setOwner};
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single processor-memory port between the icache and dcache
// and steers memory responses back to whichever cache issued the load.
// Ports:
//   clock, reset                       clock, asynchronous active-low reset
//   icache_command/icache_addr         icache request
//   dcache_command/dcache_addr/data    dcache request
//   mem2proc_transaction_tag           accept tag this cycle (0 = rejected)
//   mem2proc_data/mem2proc_data_tag    returning data and its tag
//   proc2mem_command/addr/data         request of the granted cache
//   icache_grant/dcache_grant          current port owner
//   dcache_request                     dcache has a pending request
//   Imem2proc_*/Dmem2proc_*            per-cache routed tags and data
//   orphan_err                         sticky: data came back for no owner
// Build option: define MEM_ARB_ANTISTARVE_EN to add the icache starvation
// counter; without it the dcache has strict priority.

import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int NUM_TAGS     = `NUM_MEM_TAGS,
    parameter int STARVE_LIMIT = `MEM_ARB_STARVE_LIMIT
) (
    input  logic       clock,
    input  logic       reset,
    input  MEM_COMMAND icache_command,
    input  ADDR        icache_addr,
    input  MEM_COMMAND dcache_command,
    input  ADDR        dcache_addr,
    input  MEM_BLOCK   dcache_data,
    input  MEM_TAG     mem2proc_transaction_tag,
    input  MEM_BLOCK   mem2proc_data,
    input  MEM_TAG     mem2proc_data_tag,
    output MEM_COMMAND proc2mem_command,
    output ADDR        proc2mem_addr,
    output MEM_BLOCK   proc2mem_data,
    output logic       icache_grant,
    output logic       dcache_grant,
    output logic       dcache_request,
    output MEM_TAG     Imem2proc_transaction_tag,
    output MEM_TAG     Imem2proc_data_tag,
    output MEM_TAG     Dmem2proc_transaction_tag,
    output MEM_TAG     Dmem2proc_data_tag,
    output MEM_BLOCK   Imem2proc_data,
    output MEM_BLOCK   Dmem2proc_data,
    output logic       orphan_err
);

    logic         w_iReq;
    logic         w_dReq;
    logic         w_override;
    logic         w_iGrant;
    logic         w_dGrant;
    logic         w_setEn;
    logic         w_retValid;
    logic         w_orphan;
    MEM_ARB_ENTRY w_rdEntry;
    logic         r_orphanErr;

    assign w_iReq = (icache_command != MEM_NONE);
    assign w_dReq = (dcache_command != MEM_NONE);

`ifdef MEM_ARB_ANTISTARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starveCnt;

    assign w_override = (r_starveCnt == CNT_W'(STARVE_LIMIT));

    // Count consecutive cycles the icache waits behind the dcache; any
    // icache grant or idle icache cycle starts the count over.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starveCnt <= '0;
        end else if (w_iReq && !w_iGrant) begin
            if (!w_override) begin
                r_starveCnt <= r_starveCnt + CNT_W'(1);
            end
        end else begin
            r_starveCnt <= '0;
        end
    end
`else
    assign w_override = 1'b0;
`endif

    // Grants are forced low during reset so nothing leaks onto the bus.
    assign w_dGrant = reset && w_dReq && !(w_override && w_iReq);
    assign w_iGrant = reset && w_iReq && !w_dGrant;

    assign icache_grant   = w_iGrant;
    assign dcache_grant   = w_dGrant;
    assign dcache_request = reset && w_dReq;

    // Drive the memory port with whichever cache holds the grant; only a
    // dcache store carries meaningful write data.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (w_dGrant) begin
            proc2mem_command = dcache_command;
            proc2mem_addr    = dcache_addr;
            proc2mem_data    = dcache_data;
        end else if (w_iGrant) begin
            proc2mem_command = icache_command;
            proc2mem_addr    = icache_addr;
        end
    end

    assign Imem2proc_transaction_tag = w_iGrant ? mem2proc_transaction_tag : '0;
    assign Dmem2proc_transaction_tag = w_dGrant ? mem2proc_transaction_tag : '0;

    // Only accepted loads need a return path; stores complete on accept.
    assign w_setEn = (proc2mem_command == MEM_LOAD) &&
                     (mem2proc_transaction_tag != '0);

    mem_tag_owner_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_ownerTable (
        .clock      (clock),
        .reset      (reset),
        .i_setEn    (w_setEn),
        .i_setTag   (mem2proc_transaction_tag),
        .i_setOwner (w_dGrant ? ARB_OWNER_D : ARB_OWNER_I),
        .i_rdTag    (mem2proc_data_tag),
        .i_clrEn    (w_retValid),
        .o_rdEntry  (w_rdEntry)
    );

    assign w_retValid = reset && (mem2proc_data_tag != '0) && w_rdEntry.valid;
    assign w_orphan   = reset && (mem2proc_data_tag != '0) && !w_rdEntry.valid;

    assign Imem2proc_data_tag = (w_retValid && w_rdEntry.owner == ARB_OWNER_I) ?
                                mem2proc_data_tag : '0;
    assign Dmem2proc_data_tag = (w_retValid && w_rdEntry.owner == ARB_OWNER_D) ?
                                mem2proc_data_tag : '0;

    assign Imem2proc_data = reset ? mem2proc_data : '0;
    assign Dmem2proc_data = reset ? mem2proc_data : '0;

    // Orphan flag latches until the next reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_orphanErr <= 1'b0;
        end else if (w_orphan) begin
            r_orphanErr <= 1'b1;
        end
    end

    assign orphan_err = r_orphanErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives directed scenarios and randomized traffic into mem_arbiter and
// compares every output against a tag-ownership model kept as a plain
// integer array plus a starvation count.

import mem_arbiter_pkg::*;

module tb_mem_arbiter;

    localparam int LIMIT = 4;

`ifdef MEM_ARB_ANTISTARVE_EN
    localparam bit ANTI_STARVE = 1'b1;
`else
    localparam bit ANTI_STARVE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    MEM_COMMAND icache_command;
    ADDR        icache_addr;
    MEM_COMMAND dcache_command;
    ADDR        dcache_addr;
    MEM_BLOCK   dcache_data;
    MEM_TAG     mem2proc_transaction_tag;
    MEM_BLOCK   mem2proc_data;
    MEM_TAG     mem2proc_data_tag;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_BLOCK   proc2mem_data;
    logic       icache_grant;
    logic       dcache_grant;
    logic       dcache_request;
    MEM_TAG     Imem2proc_transaction_tag;
    MEM_TAG     Imem2proc_data_tag;
    MEM_TAG     Dmem2proc_transaction_tag;
    MEM_TAG     Dmem2proc_data_tag;
    MEM_BLOCK   Imem2proc_data;
    MEM_BLOCK   Dmem2proc_data;
    logic       orphan_err;

    int vectorCount = 0;
    int missCount   = 0;

    // Reference state: -1 = free, 0 = icache, 1 = dcache.
    int ownerOf [0:15];
    int starve;
    bit orphanModel;

    // Expected values for the cycle currently being driven.
    bit         eI, eD, eIReq;
    MEM_COMMAND eCmd;
    ADDR        eAddr;
    MEM_BLOCK   eData;
    MEM_TAG     eITx, eDTx, eIDt, eDDt;

    mem_arbiter #(
        .NUM_TAGS     (15),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .icache_command            (icache_command),
        .icache_addr               (icache_addr),
        .dcache_command            (dcache_command),
        .dcache_addr               (dcache_addr),
        .dcache_data               (dcache_data),
        .mem2proc_transaction_tag  (mem2proc_transaction_tag),
        .mem2proc_data             (mem2proc_data),
        .mem2proc_data_tag         (mem2proc_data_tag),
        .proc2mem_command          (proc2mem_command),
        .proc2mem_addr             (proc2mem_addr),
        .proc2mem_data             (proc2mem_data),
        .icache_grant              (icache_grant),
        .dcache_grant              (dcache_grant),
        .dcache_request            (dcache_request),
        .Imem2proc_transaction_tag (Imem2proc_transaction_tag),
        .Imem2proc_data_tag        (Imem2proc_data_tag),
        .Dmem2proc_transaction_tag (Dmem2proc_transaction_tag),
        .Dmem2proc_data_tag        (Dmem2proc_data_tag),
        .Imem2proc_data            (Imem2proc_data),
        .Dmem2proc_data            (Dmem2proc_data),
        .orphan_err                (orphan_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 16; i++) ownerOf[i] = -1;
        starve      = 0;
        orphanModel = 1'b0;
    endtask

    // Drive one cycle of inputs, derive the expected outputs from the
    // arbitration rules and the ownership model, then let outputs settle.
    task automatic applyStimulus(input MEM_COMMAND ic, input ADDR ia,
                                 input MEM_COMMAND dc, input ADDR da,
                                 input MEM_BLOCK dd, input MEM_TAG tx,
                                 input MEM_TAG dt, input MEM_BLOCK md);
        bit dReq, override;
        int retOwner;
        icache_command           = ic;
        icache_addr              = ia;
        dcache_command           = dc;
        dcache_addr              = da;
        dcache_data              = dd;
        mem2proc_transaction_tag = tx;
        mem2proc_data_tag        = dt;
        mem2proc_data            = md;
        eIReq    = (ic != MEM_NONE);
        dReq     = (dc != MEM_NONE);
        override = ANTI_STARVE && (starve == LIMIT);
        eD       = dReq && !(override && eIReq);
        eI       = eIReq && !eD;
        eCmd     = eD ? dc : (eI ? ic : MEM_NONE);
        eAddr    = eD ? da : (eI ? ia : '0);
        eData    = eD ? dd : '0;
        eITx     = eI ? tx : '0;
        eDTx     = eD ? tx : '0;
        retOwner = (dt != 0) ? ownerOf[dt] : -1;
        eIDt     = (retOwner == 0) ? dt : '0;
        eDDt     = (retOwner == 1) ? dt : '0;
        #3;
    endtask

    task automatic checkModel();
        checkOutput("igrant", icache_grant, eI);
        checkOutput("dgrant", dcache_grant, eD);
        checkOutput("cmd", proc2mem_command, eCmd);
        checkOutput("addr", proc2mem_addr, eAddr);
        checkOutput("wdata", proc2mem_data, eData);
        checkOutput("dreq", dcache_request, dcache_command != MEM_NONE);
        checkOutput("itx", Imem2proc_transaction_tag, eITx);
        checkOutput("dtx", Dmem2proc_transaction_tag, eDTx);
        checkOutput("idt", Imem2proc_data_tag, eIDt);
        checkOutput("ddt", Dmem2proc_data_tag, eDDt);
        checkOutput("idata", Imem2proc_data, mem2proc_data);
        checkOutput("ddata", Dmem2proc_data, mem2proc_data);
        checkOutput("orphan", orphan_err, orphanModel);
    endtask

    // Step past the clock edge and apply the same cycle to the model:
    // returns free their tag first, a newly accepted load then claims one.
    task automatic advance();
        @(posedge clock);
        #1;
        if (mem2proc_data_tag != 0) begin
            if (ownerOf[mem2proc_data_tag] < 0) orphanModel = 1'b1;
            else ownerOf[mem2proc_data_tag] = -1;
        end
        if (eCmd == MEM_LOAD && mem2proc_transaction_tag != 0)
            ownerOf[mem2proc_transaction_tag] = eD ? 1 : 0;
        if (eIReq && !eI) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
        else starve = 0;
    endtask

    task automatic idleCycle();
        applyStimulus(MEM_NONE, '0, MEM_NONE, '0, '0, '0, '0, '0);
        checkModel();
        advance();
    endtask

    // Pulse reset away from any clock edge, checking that it acts at once.
    task automatic asyncReset();
        reset = 1'b0;
        #1;
        checkOutput("rst_orphan", orphan_err, 1'b0);
        checkOutput("rst_dgrant", dcache_grant, 1'b0);
        checkOutput("rst_igrant", icache_grant, 1'b0);
        resetModel();
        applyStimulus(MEM_NONE, '0, MEM_NONE, '0, '0, '0, '0, '0);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit granted5;
        resetModel();

        // Busy inputs while in reset: everything must stay quiet.
        icache_command           = MEM_LOAD;
        icache_addr              = 32'h40;
        dcache_command           = MEM_STORE;
        dcache_addr              = 32'h80;
        dcache_data              = 64'hDEAD;
        mem2proc_transaction_tag = 4'd2;
        mem2proc_data_tag        = 4'd4;
        mem2proc_data            = 64'hABC;
        #2;
        checkOutput("rst_ig", icache_grant, 1'b0);
        checkOutput("rst_dg", dcache_grant, 1'b0);
        checkOutput("rst_cmd", proc2mem_command, MEM_NONE);
        checkOutput("rst_dreq", dcache_request, 1'b0);
        checkOutput("rst_itx", Imem2proc_transaction_tag, 4'd0);
        checkOutput("rst_dtx", Dmem2proc_transaction_tag, 4'd0);
        checkOutput("rst_idt", Imem2proc_data_tag, 4'd0);
        checkOutput("rst_ddt", Dmem2proc_data_tag, 4'd0);
        checkOutput("rst_idata", Imem2proc_data, 64'd0);
        checkOutput("rst_ddata", Dmem2proc_data, 64'd0);
        checkOutput("rst_orph", orphan_err, 1'b0);
        @(negedge clock);
        applyStimulus(MEM_NONE, '0, MEM_NONE, '0, '0, '0, '0, '0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // icache-only load, tag 3, data back two cycles later.
        applyStimulus(MEM_LOAD, 32'h100, MEM_NONE, '0, '0, 4'd3, '0, '0);
        checkModel();
        checkOutput("d1_itx", Imem2proc_transaction_tag, 4'd3);
        checkOutput("d1_addr", proc2mem_addr, 32'h100);
        advance();
        idleCycle();
        applyStimulus(MEM_NONE, '0, MEM_NONE, '0, '0, '0, 4'd3, 64'h1111);
        checkModel();
        checkOutput("d1_idt", Imem2proc_data_tag, 4'd3);
        checkOutput("d1_ddt", Dmem2proc_data_tag, 4'd0);
        advance();

        // Both request together: dcache wins and gets tag 5.
        applyStimulus(MEM_LOAD, 32'h200, MEM_LOAD, 32'h300, 64'h55, 4'd5, '0, '0);
        checkModel();
        checkOutput("d2_dg", dcache_grant, 1'b1);
        checkOutput("d2_addr", proc2mem_addr, 32'h300);
        checkOutput("d2_dtx", Dmem2proc_transaction_tag, 4'd5);
        checkOutput("d2_itx", Imem2proc_transaction_tag, 4'd0);
        advance();
        applyStimulus(MEM_NONE, '0, MEM_NONE, '0, '0, '0, 4'd5, 64'h2222);
        checkModel();
        checkOutput("d2_ddt", Dmem2proc_data_tag, 4'd5);
        advance();

        // Tag 7 returns to the dcache while the icache reissues tag 7.
        applyStimulus(MEM_NONE, '0, MEM_LOAD, 32'h700, '0, 4'd7, '0, '0);
        checkModel();
        advance();
        applyStimulus(MEM_LOAD, 32'h710, MEM_NONE, '0, '0, 4'd7, 4'd7, 64'h77);
        checkModel();
        checkOutput("t7_ddt", Dmem2proc_data_tag, 4'd7);
        checkOutput("t7_idt", Imem2proc_data_tag, 4'd0);
        advance();
        applyStimulus(MEM_NONE, '0, MEM_NONE, '0, '0, '0, 4'd7, 64'h78);
        checkModel();
        checkOutput("t7_new_idt", Imem2proc_data_tag, 4'd7);
        advance();

        // Continuous dcache traffic with a waiting icache (all rejected).
        idleCycle();
        granted5 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(MEM_LOAD, 32'h900, MEM_LOAD, 32'hA00, '0, '0, '0, '0);
            checkModel();
            if (k == 5) granted5 = icache_grant;
            advance();
        end
        checkOutput("starve_5th", granted5, ANTI_STARVE);
        idleCycle();

        // Orphan return for tag 9, held, then cleared asynchronously.
        applyStimulus(MEM_NONE, '0, MEM_NONE, '0, '0, '0, 4'd9, 64'h99);
        checkModel();
        checkOutput("orph_idt", Imem2proc_data_tag, 4'd0);
        checkOutput("orph_ddt", Dmem2proc_data_tag, 4'd0);
        advance();
        idleCycle();
        checkOutput("orph_held", orphan_err, 1'b1);
        idleCycle();
        asyncReset();

        // Randomized traffic in rounds separated by resets, so the sticky
        // orphan flag is re-exercised.
        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < 60; n++) begin
                MEM_COMMAND ic, dc;
                MEM_TAG tx, dt, pick;
                ic   = ($urandom_range(0, 1) == 1) ? MEM_LOAD : MEM_NONE;
                dc   = MEM_COMMAND'(2'($urandom_range(0, 2)));
                tx   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                pick = 4'($urandom_range(1, 15));
                if (ownerOf[pick] >= 0 && $urandom_range(0, 1) == 1) dt = pick;
                else if (ownerOf[pick] < 0 && $urandom_range(0, 15) == 0) dt = pick;
                else dt = 4'd0;
                applyStimulus(ic, $urandom, dc, $urandom, {$urandom, $urandom},
                              tx, dt, {$urandom, $urandom});
                checkModel();
                advance();
            end
            asyncReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
